mmio_sync_fifo: RTL and testbench

//   Parametrised synchronous circular-buffer FIFO for MMIO-mapped user queues in the AFU.

---
 rtl/mmio_sync_fifo.sv | 146 ++++++++++++++
 tb/tb_mmio_sync_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: circular-buffer FIFO behind host MMIO push/pop pulses.
// Every pop gets a registered one-cycle response. A pop on an empty FIFO
// returns zero data. The FIFO reports occupancy, full/empty/almost-full and
// sticky overflow/underflow errors, and supports a synchronous flush.
module mmio_sync_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             flush,
  input  logic             clr_err,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Storage is never reset. The pointers and count alone decide which
  // entries are live.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic full_int, empty_int;
  logic push_acc, pop_acc;
  logic ov_set, uf_set;

  // Advance a pointer, wrapping at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status flags decode directly from the registered occupancy.
  always_comb begin
    full_int    = (count_reg == CW'(DEPTH));
    empty_int   = (count_reg == '0);
    full        = full_int;
    empty       = empty_int;
    almost_full = (count_reg >= CW'(AF_THRESH));
  end

  // Accept and reject decisions. A flush suppresses every push/pop effect.
  // A pop frees a slot, so a push on a full FIFO still succeeds when it
  // pairs with a pop.
  always_comb begin
    pop_acc  = pop && !empty_int && !flush;
    push_acc = push && (!full_int || pop_acc) && !flush;
    ov_set   = push && !flush && !push_acc;
    uf_set   = pop && !flush && empty_int;
  end

  // Next-state logic for the pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_acc) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop_acc)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push_acc && !pop_acc)
        count_next = count_reg + CW'(1);
      else if (pop_acc && !push_acc)
        count_next = count_reg - CW'(1);
    end

    // If an error event and clr_err arrive together, the new event wins.
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (ov_set) overflow_next  = 1'b1;
    if (uf_set) underflow_next = 1'b1;
  end

  // State register for the pointers, occupancy and error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc)
      mem[wr_ptr_reg] <= wr_data;
  end

  // Registered read port. A full FIFO with push+pop has wr_ptr == rd_ptr;
  // the read samples the old head before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= pop_acc || uf_set;
      if (pop_acc)
        rd_data_reg <= mem[rd_ptr_reg];
      else if (uf_set)
        rd_data_reg <= '0;
    end
  end

  // Drive the outputs from the registered state.
  always_comb begin
    rd_data   = rd_data_reg;
    rd_valid  = rd_valid_reg;
    count     = count_reg;
    overflow  = overflow_reg;
    underflow = underflow_reg;
  end

endmodule

// File: tb/tb_mmio_sync_fifo.sv
// tb_mmio_sync_fifo: directed scenarios followed by biased random traffic.
// A queue-based reference model drives expectations. Every pop pushes the
// expected response into a scoreboard. A separate monitor checks responses
// and status after each clock edge.
module tb_mmio_sync_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, push, pop, flush, clr_err;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, almost_full, overflow, underflow;
  logic [CW-1:0]    count;

  mmio_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush), .clr_err(clr_err),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents, sticky errors, last returned data.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ov, m_uf;
  logic [WIDTH-1:0] last_rd;
  bit               mon_en = 1'b0;
  int               checks = 0;
  int               failures = 0;
  int               txn = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, txn, act, req);
    end
  endtask

  // One clock of stimulus. The model state always describes the DUT after
  // the next rising edge.
  task automatic cycle(input logic p, input logic [WIDTH-1:0] d, input logic q,
                       input logic f, input logic c, input logic r);
    logic pop_ok, push_ok;
    @(negedge clk);
    rst_n = r; push = p; wr_data = d; pop = q; flush = f; clr_err = c;
    txn++;
    if (!r) begin
      model_q.delete();
      m_ov = 1'b0; m_uf = 1'b0; last_rd = '0;
    end else if (f) begin
      model_q.delete();
      if (c) begin m_ov = 1'b0; m_uf = 1'b0; end
    end else begin
      pop_ok  = q && (model_q.size() > 0);
      push_ok = p && (model_q.size() < DEPTH || pop_ok);
      if (q) exp_q.push_back(pop_ok ? model_q[0] : '0);
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
      if (c) begin m_ov = 1'b0; m_uf = 1'b0; end
      if (p && !push_ok) m_ov = 1'b1;
      if (q && !pop_ok) m_uf = 1'b1;
    end
    $display("txn %0d rst_n=%0b push=%0b pop=%0b flush=%0b clr=%0b data=0x%0h model_count=%0d",
             txn, r, p, q, f, c, d, model_q.size());
  endtask

  // Monitor: compares the DUT against the model 1 ns after every rising edge.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("rd_valid", WIDTH'(rd_valid), WIDTH'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (rd_valid) chk("rd_data", rd_data, e);
          last_rd = e;
        end else begin
          chk("rd_data_hold", rd_data, last_rd);
        end
        chk("count", WIDTH'(count), WIDTH'(model_q.size()));
        chk("full", WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
        chk("empty", WIDTH'(empty), WIDTH'(model_q.size() == 0));
        chk("almost_full", WIDTH'(almost_full), WIDTH'(model_q.size() >= AF));
        chk("overflow", WIDTH'(overflow), WIDTH'(m_ov));
        chk("underflow", WIDTH'(underflow), WIDTH'(m_uf));
      end
    end
  end

  initial begin
    int ph;
    logic p, q, f, c, r;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_data = '0;
    last_rd = '0;
    cycle(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);

    // Basic ordering with a one-cycle read latency.
    cycle(1, 64'h11, 0, 0, 0, 1);
    cycle(1, 64'h22, 0, 0, 0, 1);
    cycle(1, 64'h33, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Fill to full, then overflow on the 17th push and pop the first value.
    for (int i = 0; i < DEPTH; i++) cycle(1, 64'h100 + i, 0, 0, 0, 1);
    cycle(1, 64'hDEAD, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);

    // Drain, then underflow. Clear the flag, then check that set beats clear.
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);

    // Full with push+pop: the old head is returned, then a drain covers the wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1, 64'h200 + i, 0, 0, 0, 1);
    cycle(1, 64'hAA, 1, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);

    // Empty with push+pop: the pop is rejected and the push is kept.
    cycle(1, 64'h5, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Flush beats a same-cycle push. Then a reset arrives mid-stream.
    for (int i = 0; i < 5; i++) cycle(1, 64'h300 + i, 0, 0, 0, 1);
    cycle(1, 64'h3FF, 1, 1, 0, 1);
    cycle(1, 64'h400, 0, 0, 0, 1);
    cycle(1, 64'h401, 1, 0, 0, 1);
    cycle(1, 64'h402, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Biased random traffic: fill, drain and balanced phases in turn.
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 150) % 3;
      p = ($urandom_range(0, 99) < ((ph == 0) ? 80 : (ph == 1) ? 20 : 50));
      q = ($urandom_range(0, 99) < ((ph == 0) ? 20 : (ph == 1) ? 80 : 50));
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 499) != 0);
      cycle(p, {$urandom, $urandom}, q, f, c, r);
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
